// File: rtl/baud_pkg.sv
// Shared constants, preset divisors and helpers for the baud tick generator.
// Presets assume a 100 MHz clock and x16 oversampling.
package baud_pkg;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR    = 16;

  localparam int BAUD_9600_DIV    = 651;
  localparam int BAUD_9600_FRAC   = 1;
  localparam int BAUD_115200_DIV  = 54;
  localparam int BAUD_115200_FRAC = 4;

  // state | meaning
  // CFG_IDLE    | no divisor waiting, cfg_ready high
  // CFG_PENDING | shadow holds a divisor waiting for a period boundary
  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_t;

  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/baud_period_counter.sv
// Sample-period counter with divisor clamp and optional fractional accumulator.
// Fractional stretch is built only when BAUD_FRAC_EN is defined.
module baud_period_counter #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync_clear,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div,
  input  logic [FRAC_W-1:0] frac,
  output logic              wrap
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W:0]   last;
  logic             carry;

  // Divisors below 2 would make ticks back-to-back; treat them as 2.
  assign div_eff = (div < DIV_W'(2)) ? DIV_W'(2) : div;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic              carry_q;

  assign carry = carry_q;

  // carry_q stretches the period that follows the overflowing wrap by one clock.
  always_ff @(posedge clk_100MHz) begin
    if (reset || sync_clear || restart) begin
      acc     <= '0;
      carry_q <= 1'b0;
    end else if (wrap) begin
      {carry_q, acc} <= {1'b0, acc} + {1'b0, frac};
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^frac;
  assign carry       = 1'b0;
`endif

  assign last = {1'b0, div_eff} + {{DIV_W{1'b0}}, carry} - (DIV_W+1)'(1);
  assign wrap = enable && !sync_clear && ({1'b0, cnt} == last);

  always_ff @(posedge clk_100MHz) begin
    if (reset || sync_clear || restart) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Runtime-programmable baud tick generator: sample_tick per sample period, bit_tick per OSR samples.
// Define BAUD_FRAC_EN to enable the fractional divisor.
module baud_tick_gen #(
  parameter int DIV_W        = baud_pkg::DIV_W,
  parameter int FRAC_W       = baud_pkg::FRAC_W,
  parameter int OSR          = baud_pkg::OSR,
  parameter int DEFAULT_DIV  = 651,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync_clear,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [FRAC_W-1:0] cfg_frac,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic [DIV_W-1:0]  active_div
);
  import baud_pkg::*;

  // state       | meaning
  // CFG_IDLE    | ready for a new divisor
  // CFG_PENDING | divisor captured, applied at next wrap / enable low / sync_clear

  localparam int OS_W = CLOG2(OSR);

  cfg_state_t        cfg_state;
  logic [DIV_W-1:0]  shadow_div;
  logic [FRAC_W-1:0] shadow_frac;
  logic [FRAC_W-1:0] active_frac;
  logic [OS_W-1:0]   os_cnt;
  logic              wrap;
  logic              accept;
  logic              apply_ev;
  logic              apply_now;

  assign accept    = cfg_valid && cfg_ready;
  assign apply_ev  = wrap || !enable || sync_clear;
  assign apply_now = (cfg_state == CFG_PENDING) && apply_ev;

  baud_period_counter #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_period (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .enable     (enable),
    .sync_clear (sync_clear),
    .restart    (apply_now),
    .div        (active_div),
    .frac       (active_frac),
    .wrap       (wrap)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cfg_state   <= CFG_IDLE;
      cfg_ready   <= 1'b1;
      shadow_div  <= DIV_W'(DEFAULT_DIV);
      shadow_frac <= FRAC_W'(DEFAULT_FRAC);
      active_div  <= DIV_W'(DEFAULT_DIV);
      active_frac <= FRAC_W'(DEFAULT_FRAC);
    end else begin
      case (cfg_state)
        CFG_IDLE: begin
          if (accept) begin
            shadow_div  <= cfg_div;
            shadow_frac <= cfg_frac;
            cfg_state   <= CFG_PENDING;
            cfg_ready   <= 1'b0;
          end
        end
        CFG_PENDING: begin
          if (apply_ev) begin
            active_div  <= shadow_div;
            active_frac <= shadow_frac;
            cfg_state   <= CFG_IDLE;
            cfg_ready   <= 1'b1;
          end
        end
        default: cfg_state <= CFG_IDLE;
      endcase
    end
  end

  // The wrap that applies a new divisor still ticks; os_cnt only restarts on sync_clear.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      os_cnt      <= '0;
      sample_tick <= 1'b0;
      bit_tick    <= 1'b0;
    end else begin
      sample_tick <= wrap;
      bit_tick    <= wrap && (os_cnt == OS_W'(OSR - 1));
      if (sync_clear) begin
        os_cnt <= '0;
      end else if (wrap) begin
        os_cnt <= (os_cnt == OS_W'(OSR - 1)) ? '0 : os_cnt + OS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: stimulus queues absolute tick cycles, a negedge monitor pops and compares.
module tb_baud_tick_gen;

`ifdef BAUD_FRAC_EN
  localparam int FE = 1;
`else
  localparam int FE = 0;
`endif

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b1;
  logic        enable     = 1'b0;
  logic        sync_clear = 1'b0;
  logic [15:0] cfg_div    = '0;
  logic [3:0]  cfg_frac   = '0;
  logic        cfg_valid  = 1'b0;
  logic        cfg_ready;
  logic        sample_tick;
  logic        bit_tick;
  logic [15:0] active_div;

  typedef struct {
    int   cyc;
    logic bt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  baud_tick_gen dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .enable      (enable),
    .sync_clear  (sync_clear),
    .cfg_div     (cfg_div),
    .cfg_frac    (cfg_frac),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .sample_tick (sample_tick),
    .bit_tick    (bit_tick),
    .active_div  (active_div)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  // Monitor: every sample_tick must match the head of the expected queue.
  always @(negedge clk_100MHz) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_tick actual=none required_cycle=%0d now=%0d", exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (sample_tick) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_tick actual_cycle=%0d required=none", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.bt !== bit_tick) begin
          failures++;
          $display("FAIL tick actual_cycle=%0d actual_bit=%0b required_cycle=%0d required_bit=%0b",
                   cyc, bit_tick, e.cyc, e.bt);
        end
      end
    end else if (bit_tick) begin
      checks++;
      failures++;
      $display("FAIL lone_bit_tick actual=1 required=0 cycle=%0d", cyc);
    end
  end

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic push(input int c, input logic b);
    exp_t e;
    e.cyc = c;
    e.bt  = b;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  initial begin
    int n0, t, u, v, w;

    // Reset values
    repeat (3) step();
    check("rst_sample_tick", int'(sample_tick), 0);
    check("rst_bit_tick", int'(bit_tick), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_active_div", int'(active_div), 651);
    reset = 1'b0;
    step();

    // Defaults: period 651, bit every 16 samples, first tick on edge L+1 after enable
    n0 = cyc;
    enable = 1'b1;
    for (int j = 1; j <= 32; j++) push(n0 + 651 * j, (j % 16) == 0);
    wait_until(n0 + 32 * 651);
    t = cyc;

    // Mid-period handshake to 54; a second offer while pending is ignored
    wait_until(t + 100);
    check("ready_idle", int'(cfg_ready), 1);
    cfg_div = 16'd54; cfg_frac = 4'd0; cfg_valid = 1'b1;
    step();
    check("ready_fall", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    push(t + 651, 1'b0);
    for (int j = 34; j <= 48; j++) push(t + 651 + 54 * (j - 33), j == 48);
    wait_until(t + 200);
    cfg_div = 16'd99; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0; cfg_div = 16'd54;
    check("ready_still_low", int'(cfg_ready), 0);
    wait_until(t + 650);
    check("old_div_held", int'(active_div), 651);
    check("ready_low_before_apply", int'(cfg_ready), 0);
    step();
    check("new_div_applied", int'(active_div), 54);
    check("ready_rise", int'(cfg_ready), 1);
    wait_until(t + 651 + 54 * 15);
    u = cyc;

    // div=54 frac=4: periods 54,54,54,54,55,... with fractional build
    wait_until(u + 10);
    cfg_div = 16'd54; cfg_frac = 4'd4; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    push(u + 54, 1'b0);
    t = u + 54;
    for (int k = 1; k <= 17; k++) begin
      t = t + 54 + ((FE == 1 && (k % 4) == 1 && k > 1) ? 1 : 0);
      push(t, ((49 + k) % 16) == 0);
    end
    wait_until(t);
    v = cyc;

    // enable low for 100 cycles mid-period delays the next tick by 100
    t = v + 100;
    for (int k = 18; k <= 21; k++) begin
      t = t + 54 + ((FE == 1 && (k % 4) == 1) ? 1 : 0);
      push(t, ((49 + k) % 16) == 0);
    end
    wait_until(v + 20);
    enable = 1'b0;
    wait_until(v + 120);
    enable = 1'b1;
    wait_until(t);

    // Reset, apply div=10 while disabled, then sync_clear at os_cnt=7
    reset = 1'b1; enable = 1'b0;
    step();
    step();
    check("rst2_active_div", int'(active_div), 651);
    check("rst2_cfg_ready", int'(cfg_ready), 1);
    reset = 1'b0;
    cfg_div = 16'd10; cfg_frac = 4'd0; cfg_valid = 1'b1;
    step();
    check("ready_fall_disabled", int'(cfg_ready), 0);
    cfg_valid = 1'b0;
    step();
    check("apply_on_enable_low", int'(active_div), 10);
    check("ready_rise_disabled", int'(cfg_ready), 1);
    n0 = cyc;
    enable = 1'b1;
    for (int j = 1; j <= 7; j++) push(n0 + 10 * j, 1'b0);
    for (int k = 1; k <= 16; k++) push(n0 + 74 + 10 * k, k == 16);
    wait_until(n0 + 73);
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    wait_until(n0 + 234);
    w = cyc;

    // cfg_div=1 clamps to a 2-cycle period; reset mid-run restores defaults
    wait_until(w + 3);
    cfg_div = 16'd1; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("ready_fall_clamp", int'(cfg_ready), 0);
    push(w + 10, 1'b0);
    for (int m = 1; m <= 20; m++) push(w + 10 + 2 * m, (17 + m) == 32);
    wait_until(w + 10);
    check("clamp_div_applied", int'(active_div), 1);
    wait_until(w + 51);
    reset = 1'b1;
    step();
    check("rst3_active_div", int'(active_div), 651);
    check("rst3_cfg_ready", int'(cfg_ready), 1);
    check("rst3_sample_tick", int'(sample_tick), 0);
    reset = 1'b0;
    repeat (5) step();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
